// File: rtl/reg_file_pkg.sv
// Shared widths, index/tag types and the x0 constant for the architectural
// register file and its read ports.
package reg_file_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [ROB_WIDTH-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Commits and renames aimed at x0 never touch state.
  function automatic logic is_writable(input reg_idx_t rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bundle of the register file: commit, rename, flush and
// the two operand read ports.
interface reg_file_if
  import reg_file_pkg::*;
();

  logic     clear;

  logic     from_rob;
  reg_idx_t from_rob_rd;
  rob_tag_t from_rob_tag;
  word_t    from_rob_wdata;

  logic     from_decoder;
  reg_idx_t from_decoder_rd;
  rob_tag_t from_decoder_tag;
  reg_idx_t from_decoder_rs1;
  reg_idx_t from_decoder_rs2;

  logic     to_decoder_rs1_busy;
  logic     to_decoder_rs2_busy;
  rob_tag_t to_decoder_rs1_tag;
  rob_tag_t to_decoder_rs2_tag;
  word_t    to_decoder_rs1_val;
  word_t    to_decoder_rs2_val;

  modport master (
    output clear,
    output from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
    output from_decoder, from_decoder_rd, from_decoder_tag,
    output from_decoder_rs1, from_decoder_rs2,
    input  to_decoder_rs1_busy, to_decoder_rs2_busy,
    input  to_decoder_rs1_tag, to_decoder_rs2_tag,
    input  to_decoder_rs1_val, to_decoder_rs2_val
  );

  modport slave (
    input  clear,
    input  from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
    input  from_decoder, from_decoder_rd, from_decoder_tag,
    input  from_decoder_rs1, from_decoder_rs2,
    output to_decoder_rs1_busy, to_decoder_rs2_busy,
    output to_decoder_rs1_tag, to_decoder_rs2_tag,
    output to_decoder_rs1_val, to_decoder_rs2_val
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup: state read, x0 forcing and bypass of a
// same-cycle commit from the current producer.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  reg_idx_t                          rs,
  input  logic [REG_COUNT-1:0]              busy,
  input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tags,
  input  logic [REG_COUNT-1:0][XLEN-1:0]    vals,
  input  logic                              commit_valid,
  input  reg_idx_t                          commit_rd,
  input  rob_tag_t                          commit_tag,
  input  word_t                             commit_wdata,
  output logic                              rs_busy,
  output rob_tag_t                          rs_tag,
  output word_t                             rs_val
);

  logic commit_hits;

  assign commit_hits = commit_valid && (commit_rd == rs) && busy[rs] &&
                       (tags[rs] == commit_tag);

  // Only the producer named by the tag may resolve the operand early; a
  // commit from an older producer leaves the younger rename visible.
  always_comb begin
    rs_busy = busy[rs];
    rs_tag  = tags[rs];
    rs_val  = vals[rs];
    if (rs == REG_ZERO) begin
      rs_busy = 1'b0;
      rs_tag  = '0;
      rs_val  = '0;
    end else if (commit_hits) begin
      rs_busy = 1'b0;
      rs_val  = commit_wdata;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Committed integer register file with per-register busy bit and youngest
// producer tag; retires ROB results, renames decoder destinations, flushes.
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  reg_file_if.slave rf
);

  logic [REG_COUNT-1:0][XLEN-1:0]      val_q, val_d;
  logic [REG_COUNT-1:0]                busy_q, busy_d;
  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag_q, tag_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = rf.from_rob && is_writable(rf.from_rob_rd);
  assign rename_en = rf.from_decoder && is_writable(rf.from_decoder_rd);

  // Rename is applied after commit so it wins on a shared rd; clear
  // overrides every busy bit and swallows the rename, but not the value.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (commit_en) begin
        val_d[rf.from_rob_rd] = rf.from_rob_wdata;
        if (busy_q[rf.from_rob_rd] && (tag_q[rf.from_rob_rd] == rf.from_rob_tag)) begin
          busy_d[rf.from_rob_rd] = 1'b0;
        end
      end
      if (rf.clear) begin
        busy_d = '0;
      end else if (rename_en) begin
        busy_d[rf.from_decoder_rd] = 1'b1;
        tag_d[rf.from_decoder_rd]  = rf.from_decoder_tag;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  reg_file_read_port u_rs1 (
    .rs           (rf.from_decoder_rs1),
    .busy         (busy_q),
    .tags         (tag_q),
    .vals         (val_q),
    .commit_valid (rf.from_rob),
    .commit_rd    (rf.from_rob_rd),
    .commit_tag   (rf.from_rob_tag),
    .commit_wdata (rf.from_rob_wdata),
    .rs_busy      (rf.to_decoder_rs1_busy),
    .rs_tag       (rf.to_decoder_rs1_tag),
    .rs_val       (rf.to_decoder_rs1_val)
  );

  reg_file_read_port u_rs2 (
    .rs           (rf.from_decoder_rs2),
    .busy         (busy_q),
    .tags         (tag_q),
    .vals         (val_q),
    .commit_valid (rf.from_rob),
    .commit_rd    (rf.from_rob_rd),
    .commit_tag   (rf.from_rob_tag),
    .commit_wdata (rf.from_rob_wdata),
    .rs_busy      (rf.to_decoder_rs2_busy),
    .rs_tag       (rf.to_decoder_rs2_tag),
    .rs_val       (rf.to_decoder_rs2_val)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, bypass, clear, x0 and stall.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk_in;
  logic rst_in;
  logic rdy_in;

  int checks;
  int errors;

  reg_file_if bus ();

  reg_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rf     (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.clear          = 1'b0;
    bus.from_rob       = 1'b0;
    bus.from_rob_rd    = '0;
    bus.from_rob_tag   = '0;
    bus.from_rob_wdata = '0;
    bus.from_decoder   = 1'b0;
    bus.from_decoder_rd  = '0;
    bus.from_decoder_tag = '0;
  endtask

  task automatic applyStimulus(input logic rob, input reg_idx_t rob_rd,
                               input rob_tag_t rob_tag, input word_t wdata,
                               input logic dec, input reg_idx_t dec_rd,
                               input rob_tag_t dec_tag, input logic clr);
    bus.from_rob         = rob;
    bus.from_rob_rd      = rob_rd;
    bus.from_rob_tag     = rob_tag;
    bus.from_rob_wdata   = wdata;
    bus.from_decoder     = dec;
    bus.from_decoder_rd  = dec_rd;
    bus.from_decoder_tag = dec_tag;
    bus.clear            = clr;
  endtask

  task automatic readRegs(input reg_idx_t rs1, input reg_idx_t rs2);
    bus.from_decoder_rs1 = rs1;
    bus.from_decoder_rs2 = rs2;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    readRegs(5'd0, 5'd0);
    cycle();
    cycle();
    rst_in = 1'b0;

    readRegs(5'd5, 5'd0);
    checkOutput("reset_rs1_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("reset_rs1_tag",  32'(bus.to_decoder_rs1_tag),  32'd0);
    checkOutput("reset_rs1_val",  bus.to_decoder_rs1_val,       32'd0);
    checkOutput("reset_rs2_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);
    checkOutput("reset_rs2_tag",  32'(bus.to_decoder_rs2_tag),  32'd0);
    checkOutput("reset_rs2_val",  bus.to_decoder_rs2_val,       32'd0);

    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd3, 4'd7, 1'b0);
    cycle();
    idle();
    readRegs(5'd3, 5'd3);
    checkOutput("ren_x3_rs1_busy", 32'(bus.to_decoder_rs1_busy), 32'd1);
    checkOutput("ren_x3_rs1_tag",  32'(bus.to_decoder_rs1_tag),  32'd7);
    checkOutput("ren_x3_rs2_busy", 32'(bus.to_decoder_rs2_busy), 32'd1);
    checkOutput("ren_x3_rs2_tag",  32'(bus.to_decoder_rs2_tag),  32'd7);

    applyStimulus(1'b1, 5'd3, 4'd7, 32'h0000_DEAD, 1'b0, 5'd0, 4'd0, 1'b0);
    readRegs(5'd3, 5'd3);
    checkOutput("byp_x3_rs1_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("byp_x3_rs1_val",  bus.to_decoder_rs1_val,       32'h0000_DEAD);
    checkOutput("byp_x3_rs2_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);
    checkOutput("byp_x3_rs2_val",  bus.to_decoder_rs2_val,       32'h0000_DEAD);
    cycle();
    idle();
    readRegs(5'd3, 5'd0);
    checkOutput("st_x3_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("st_x3_val",  bus.to_decoder_rs1_val,       32'h0000_DEAD);

    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd4, 4'd2, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd4, 4'd5, 1'b0);
    cycle();
    applyStimulus(1'b1, 5'd4, 4'd2, 32'd11, 1'b0, 5'd0, 4'd0, 1'b0);
    readRegs(5'd4, 5'd0);
    checkOutput("old_cmt_nobyp_busy", 32'(bus.to_decoder_rs1_busy), 32'd1);
    checkOutput("old_cmt_nobyp_val",  bus.to_decoder_rs1_val,       32'd0);
    cycle();
    idle();
    readRegs(5'd0, 5'd4);
    checkOutput("old_cmt_val",  bus.to_decoder_rs2_val,       32'd11);
    checkOutput("old_cmt_busy", 32'(bus.to_decoder_rs2_busy), 32'd1);
    checkOutput("old_cmt_tag",  32'(bus.to_decoder_rs2_tag),  32'd5);
    applyStimulus(1'b1, 5'd4, 4'd5, 32'd22, 1'b0, 5'd0, 4'd0, 1'b0);
    cycle();
    idle();
    readRegs(5'd4, 5'd0);
    checkOutput("new_cmt_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("new_cmt_val",  bus.to_decoder_rs1_val,       32'd22);

    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd6, 4'd1, 1'b0);
    cycle();
    applyStimulus(1'b1, 5'd6, 4'd1, 32'd9, 1'b1, 5'd6, 4'd8, 1'b0);
    readRegs(5'd6, 5'd0);
    checkOutput("same_rd_byp_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("same_rd_byp_val",  bus.to_decoder_rs1_val,       32'd9);
    cycle();
    idle();
    readRegs(5'd6, 5'd0);
    checkOutput("same_rd_busy", 32'(bus.to_decoder_rs1_busy), 32'd1);
    checkOutput("same_rd_tag",  32'(bus.to_decoder_rs1_tag),  32'd8);
    checkOutput("same_rd_val",  bus.to_decoder_rs1_val,       32'd9);

    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd1, 4'd1, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd2, 4'd2, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd9, 4'd3, 1'b0);
    cycle();
    idle();
    readRegs(5'd1, 5'd9);
    checkOutput("pre_clr_x1_busy", 32'(bus.to_decoder_rs1_busy), 32'd1);
    checkOutput("pre_clr_x9_busy", 32'(bus.to_decoder_rs2_busy), 32'd1);
    applyStimulus(1'b1, 5'd2, 4'd9, 32'h40, 1'b1, 5'd10, 4'd4, 1'b1);
    cycle();
    idle();
    readRegs(5'd1, 5'd2);
    checkOutput("clr_x1_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("clr_x2_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);
    checkOutput("clr_x2_val",  bus.to_decoder_rs2_val,       32'h40);
    readRegs(5'd9, 5'd10);
    checkOutput("clr_x9_busy",  32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("clr_x10_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);
    readRegs(5'd6, 5'd0);
    checkOutput("clr_x6_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);

    applyStimulus(1'b1, 5'd0, 4'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 4'd3, 1'b0);
    readRegs(5'd0, 5'd0);
    checkOutput("x0_byp_busy", 32'(bus.to_decoder_rs1_busy), 32'd0);
    checkOutput("x0_byp_val",  bus.to_decoder_rs1_val,       32'd0);
    cycle();
    idle();
    readRegs(5'd0, 5'd0);
    checkOutput("x0_val",  bus.to_decoder_rs1_val,       32'd0);
    checkOutput("x0_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);
    checkOutput("x0_tag",  32'(bus.to_decoder_rs2_tag),  32'd0);

    rdy_in = 1'b0;
    applyStimulus(1'b1, 5'd7, 4'd0, 32'h77, 1'b1, 5'd8, 4'd6, 1'b0);
    cycle();
    idle();
    rdy_in = 1'b1;
    readRegs(5'd7, 5'd8);
    checkOutput("stall_x7_val",  bus.to_decoder_rs1_val,       32'd0);
    checkOutput("stall_x8_busy", 32'(bus.to_decoder_rs2_busy), 32'd0);

    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    readRegs(5'd3, 5'd6);
    checkOutput("rst2_x3_val", bus.to_decoder_rs1_val, 32'd0);
    checkOutput("rst2_x6_val", bus.to_decoder_rs2_val, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
